// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the parametrised UART receiver.
//   rx_state_e  : receiver FSM states
//   PARITY_*    : encodings of the PARITY_MODE parameter
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Front end of the UART receiver: 2-FF synchroniser on the async rx pin,
//   falling-edge detector and the bit-value decision tap.
//   Optional feature macro: UART_RX_MAJORITY_EN
//     defined   : bit_val is the 2-of-3 majority of the last three rx_s values
//                 (rx_s now, one cycle ago, two cycles ago)
//     undefined : bit_val is rx_s itself
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous reset, active-low
//   rx        in   async serial input, idles high
//   rx_s      out  synchronised rx
//   fall_det  out  1 when rx_s has just gone high -> low
//   bit_val   out  value used by the FSM for each bit decision
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall_det,
    output logic bit_val
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser flops reset to the idle (high) line level so that leaving
    // reset never produces a spurious falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s     = sync_q;
    assign fall_det = prev_q & ~sync_q;

`ifdef UART_RX_MAJORITY_EN
    logic prev2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev2_q <= 1'b1;
        end else begin
            prev2_q <= prev_q;
        end
    end

    // Taken when the FSM is at midpoint+1: sync_q = midpoint+1,
    // prev_q = midpoint, prev2_q = midpoint-1.
    assign bit_val = (sync_q & prev_q) | (sync_q & prev2_q) | (prev_q & prev2_q);
`else
    assign bit_val = sync_q;
`endif

endmodule : uart_rx_sync

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver with start-bit validation, parity / framing /
//   overrun error reporting and a valid/ready holding register.
//   Optional feature macro: UART_RX_MAJORITY_EN (3-tap majority bit decision,
//   every decision taken one cycle later than the plain midpoint sample).
// Parameters
//   CLKS_PER_BIT  clk cycles per bit (>= 8)
//   DATA_BITS     data bits per frame (5..9), LSB first
//   PARITY_MODE   0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   rx            async serial input
//   rx_data       held word (valid while rx_valid)
//   rx_valid      holding register full
//   rx_ready      consumer accepts when rx_valid && rx_ready
//   rx_done       1-cycle pulse per completed frame
//   rx_busy       start detect .. last stop sample
//   parity_err    parity result of the held word
//   frame_err     a stop bit of the held word was low
//   overrun_err   1-cycle pulse: frame completed while holding register full
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // Majority decision needs the sample after the midpoint as well.
    localparam logic [CW-1:0] START_END = CW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CW-1:0] START_END = CW'(CLKS_PER_BIT / 2 - 1);
`endif
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic rx_s;
    logic fall_det;
    logic bit_val;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_s     (rx_s),
        .fall_det (fall_det),
        .bit_val  (bit_val)
    );

    rx_state_e            state_q;
    logic [CW-1:0]        clk_c_q;
    logic [BW-1:0]        bit_c_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 done_q;
    logic                 busy_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;

    logic [DATA_BITS-1:0] shift_d;
    logic                 par_err_d;
    logic                 load_d;

    assign shift_d = {bit_val, shift_q[DATA_BITS-1:1]};

    always_comb begin
        par_err_d = 1'b0;
        if (PARITY_MODE == PARITY_EVEN) begin
            par_err_d = ^{shift_q, bit_val};
        end else if (PARITY_MODE == PARITY_ODD) begin
            par_err_d = ~(^{shift_q, bit_val});
        end
    end

    // A completed frame enters the holding register when it is empty or is
    // being drained in the same cycle; otherwise the frame is an overrun.
    assign load_d = done_q & (~rx_valid_q | rx_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clk_c_q      <= '0;
            bit_c_q      <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // fall_det already implies rx_s low; both kept for clarity.
                    if (fall_det && !rx_s) begin
                        state_q   <= START;
                        clk_c_q   <= '0;
                        busy_q    <= 1'b1;
                        par_err_q <= 1'b0;
                        frm_err_q <= 1'b0;
                    end
                end
                START: begin
                    if (clk_c_q == START_END) begin
                        clk_c_q <= '0;
                        bit_c_q <= '0;
                        if (bit_val) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        clk_c_q <= clk_c_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_c_q == BIT_END) begin
                        clk_c_q <= '0;
                        shift_q <= shift_d;
                        if (bit_c_q == LAST_DATA) begin
                            bit_c_q <= '0;
                            state_q <= (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
                        end else begin
                            bit_c_q <= bit_c_q + 1'b1;
                        end
                    end else begin
                        clk_c_q <= clk_c_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (clk_c_q == BIT_END) begin
                        clk_c_q   <= '0;
                        par_err_q <= par_err_d;
                        state_q   <= STOP;
                    end else begin
                        clk_c_q <= clk_c_q + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_c_q == BIT_END) begin
                        clk_c_q <= '0;
                        if (!bit_val) begin
                            frm_err_q <= 1'b1;
                        end
                        if (bit_c_q == LAST_STOP) begin
                            bit_c_q <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_c_q <= bit_c_q + 1'b1;
                        end
                    end else begin
                        clk_c_q <= clk_c_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Holding register: a load in the accept cycle keeps rx_valid set.
            if (load_d) begin
                rx_data_q    <= shift_q;
                parity_err_q <= par_err_q;
                // The last stop sample may still be low in frm_err_q's update;
                // it was registered on the previous edge, so frm_err_q is final.
                frame_err_q  <= frm_err_q;
                rx_valid_q   <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_done     = done_q;
    assign rx_busy     = busy_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = done_q & rx_valid_q & ~rx_ready;

endmodule : uart_rx_param

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

    localparam int C = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // DUT A: 8N1
    logic       rx_a = 1'b1;
    logic       ready_a = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, done_a, busy_a, perr_a, ferr_a, ovr_a;

    // DUT B: 8E1
    logic       rx_b = 1'b1;
    logic       ready_b = 1'b1;
    logic [7:0] data_b;
    logic       valid_b, done_b, busy_b, perr_b, ferr_b, ovr_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int ovr_cnt_a = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a),
        .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
        .rx_done(done_a), .rx_busy(busy_a), .parity_err(perr_a),
        .frame_err(ferr_a), .overrun_err(ovr_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b),
        .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
        .rx_done(done_b), .rx_busy(busy_b), .parity_err(perr_b),
        .frame_err(ferr_b), .overrun_err(ovr_b)
    );

    // Inputs change on negedge, so these posedge samples are race-free.
    // Counting cycles-high also verifies the pulses are one cycle wide.
    always @(posedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (ovr_a)  ovr_cnt_a++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        $display("check %-18s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_bit(input int sel, input logic v);
        set_line(sel, v);
        wait_cycles(C);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_lvl);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (par_en) send_bit(sel, par_bit);
        send_bit(sel, stop_lvl);
        set_line(sel, 1'b1);
    endtask

    int base_a, base_b, base_o, k;

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        wait_cycles(4);

        // Reset state
        check("rst_data",    {24'd0, data_a}, 32'h0);
        check("rst_valid",   {31'd0, valid_a}, 32'h0);
        check("rst_done",    {31'd0, done_a}, 32'h0);
        check("rst_busy",    {31'd0, busy_a}, 32'h0);
        check("rst_perr",    {31'd0, perr_a}, 32'h0);
        check("rst_ferr",    {31'd0, ferr_a}, 32'h0);
        check("rst_ovr",     {31'd0, ovr_a}, 32'h0);
        rst_n = 1'b1;
        wait_cycles(20);

        // 1. 8N1 0x42
        base_a = done_cnt_a;
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        wait_cycles(10);
        check("t1_done",  done_cnt_a - base_a, 32'd1);
        check("t1_data",  {24'd0, data_a}, 32'h42);
        check("t1_perr",  {31'd0, perr_a}, 32'h0);
        check("t1_ferr",  {31'd0, ferr_a}, 32'h0);
        check("t1_busy",  {31'd0, busy_a}, 32'h0);

        // 2. 8E1 0x6F (six ones): parity bit 1 fails, parity bit 0 passes
        ready_b = 1'b0;
        base_b = done_cnt_b;
        send_frame(1, 8'h6F, 1'b1, 1'b1, 1'b1);
        wait_cycles(10);
        check("t2a_done",  done_cnt_b - base_b, 32'd1);
        check("t2a_valid", {31'd0, valid_b}, 32'h1);
        check("t2a_data",  {24'd0, data_b}, 32'h6F);
        check("t2a_perr",  {31'd0, perr_b}, 32'h1);
        check("t2a_ferr",  {31'd0, ferr_b}, 32'h0);
        ready_b = 1'b1;
        wait_cycles(1);
        check("t2a_drain", {31'd0, valid_b}, 32'h0);
        ready_b = 1'b0;
        send_frame(1, 8'h6F, 1'b1, 1'b0, 1'b1);
        wait_cycles(10);
        check("t2b_valid", {31'd0, valid_b}, 32'h1);
        check("t2b_data",  {24'd0, data_b}, 32'h6F);
        check("t2b_perr",  {31'd0, perr_b}, 32'h0);
        ready_b = 1'b1;
        wait_cycles(2);

        // 3. 8N1 0x55 with stop bit low
        base_a = done_cnt_a;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_cycles(10);
        check("t3_done",  done_cnt_a - base_a, 32'd1);
        check("t3_ferr",  {31'd0, ferr_a}, 32'h1);
        check("t3_data",  {24'd0, data_a}, 32'h55);
        wait_cycles(C);

        // 4. False start: low for 100 cycles
        base_a = done_cnt_a;
        rx_a = 1'b0;
        wait_cycles(50);
        check("t4_busy_hi", {31'd0, busy_a}, 32'h1);
        wait_cycles(50);
        rx_a = 1'b1;
        k = 0;
        while (k < 218 && busy_a) begin
            wait_cycles(1);
            k++;
        end
        check("t4_busy_lo", {31'd0, busy_a}, 32'h0);
        wait_cycles(C);
        check("t4_no_done", done_cnt_a - base_a, 32'd0);

        // 5. Reset mid-frame, then a full 0x42
        base_a = done_cnt_a;
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        rx_a  = 1'b1;
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        check("t5_rst_data", {24'd0, data_a}, 32'h0);
        check("t5_rst_busy", {31'd0, busy_a}, 32'h0);
        wait_cycles(2 * C);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        wait_cycles(10);
        check("t5_done", done_cnt_a - base_a, 32'd1);
        check("t5_data", {24'd0, data_a}, 32'h42);

        // 6. Back-to-back 0x11, 0x22 with rx_ready low
        ready_a = 1'b0;
        wait_cycles(2);
        base_a = done_cnt_a;
        base_o = ovr_cnt_a;
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_cycles(10);
        check("t6_done",  done_cnt_a - base_a, 32'd2);
        check("t6_ovr",   ovr_cnt_a - base_o, 32'd1);
        check("t6_data",  {24'd0, data_a}, 32'h11);
        check("t6_valid", {31'd0, valid_a}, 32'h1);
        ready_a = 1'b1;
        wait_cycles(1);
        check("t6_clear", {31'd0, valid_a}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_uart_rx_param
